// File: rtl/sram_req_sched_if.sv
// -----------------------------------------------------------------------------
// sram_req_sched_if
//   Request/response channel between a requester and the SRAM request
//   scheduler.
//
//   Signals:
//     req_valid  requester has a request
//     req_ready  scheduler can accept a request this cycle
//     req_addr   request address
//     req_wdata  write data (ignored for reads)
//     req_wen    1 = write, 0 = read
//     rsp_valid  one-cycle read-response strobe
//     rsp_rdata  read data, meaningful only while rsp_valid = 1
//
//   Modports:
//     master  requester side
//     slave   scheduler side
// -----------------------------------------------------------------------------
interface sram_req_sched_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 256
);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              req_wen;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_addr, req_wdata, req_wen,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_wen,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/sram_req_sched.sv
// -----------------------------------------------------------------------------
// sram_req_sched
//   Request scheduler placed directly in front of the SRAM pins. Requests are
//   accepted over a valid/ready handshake into a small FIFO and issued one per
//   cycle, in acceptance order, onto the SRAM command pins. Reads are tracked
//   through the fixed SRAM read latency and returned as a one-cycle response.
//
//   Ports:
//     clk        clock
//     rstn       asynchronous active-low reset
//     req_if     request/response channel (slave modport)
//     sram_cs    command valid to SRAM
//     sram_addr  SRAM address (holds last value when idle)
//     sram_din   SRAM write data (0 when idle)
//     sram_wen   SRAM write enable
//     sram_dout  SRAM read data
//     busy       a request is queued, on the pins, or a read is in flight
//
//   Optional build macro SRAM_REQ_SCHED_STAT_EN adds:
//     wr_cnt     saturating count of issued writes
//     rd_cnt     saturating count of delivered read responses
// -----------------------------------------------------------------------------
module sram_req_sched #(
   parameter int ADDR_W     = 15,
   parameter int DATA_W     = 256,
   parameter int FIFO_DEPTH = 4,
   parameter int RD_LAT     = 2
) (
   input  logic                clk,
   input  logic                rstn,
   sram_req_sched_if.slave     req_if,
   output logic                sram_cs,
   output logic [ADDR_W-1:0]   sram_addr,
   output logic [DATA_W-1:0]   sram_din,
   output logic                sram_wen,
   input  logic [DATA_W-1:0]   sram_dout,
   output logic                busy
`ifdef SRAM_REQ_SCHED_STAT_EN
   ,
   output logic [31:0]         wr_cnt,
   output logic [31:0]         rd_cnt
`endif
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic                  rst_meta_q;
   logic                  rst_done_q;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [ADDR_W-1:0]     fifo_addr_q [FIFO_DEPTH];
   logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] fifo_wen_q;
   logic                  sram_cs_q, sram_cs_d;
   logic                  sram_wen_q, sram_wen_d;
   logic [ADDR_W-1:0]     sram_addr_q, sram_addr_d;
   logic [DATA_W-1:0]     sram_din_q, sram_din_d;
   logic [RD_LAT:0]       rd_pipe_q, rd_pipe_d;
   logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
   logic                  ready;
   logic                  push;
   logic                  pop;

   // Reset release is synchronised so req_ready only rises on a clean edge;
   // assertion stays asynchronous through the flop reset.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rst_meta_q <= 1'b0;
         rst_done_q <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_done_q <= rst_meta_q;
      end
   end

   // Ready is deliberately not pop-aware: a full FIFO refuses a push even on
   // a cycle where the head is being issued.
   assign ready = rst_done_q && (count_q != CNT_W'(FIFO_DEPTH));
   assign push  = req_if.req_valid && ready;
   assign pop   = (count_q != '0);

   // Next-state for pointers, occupancy, SRAM pins and the read-tracking
   // pipeline. Bit RD_LAT of the pipeline doubles as the response strobe.
   always_comb begin
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      sram_cs_d   = pop;
      sram_wen_d  = 1'b0;
      sram_din_d  = '0;
      sram_addr_d = sram_addr_q;
      if (pop) begin
         sram_wen_d  = fifo_wen_q[rd_ptr_q];
         sram_din_d  = fifo_data_q[rd_ptr_q];
         sram_addr_d = fifo_addr_q[rd_ptr_q];
      end
      rd_pipe_d   = {rd_pipe_q[RD_LAT-1:0], sram_cs_q & ~sram_wen_q};
      rsp_rdata_d = rd_pipe_q[RD_LAT-1] ? sram_dout : rsp_rdata_q;
   end

   // Control and pin registers; everything returns to idle on reset, which
   // also discards queued requests and reads in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sram_cs_q   <= 1'b0;
         sram_wen_q  <= 1'b0;
         sram_addr_q <= '0;
         sram_din_q  <= '0;
         rd_pipe_q   <= '0;
         rsp_rdata_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sram_cs_q   <= sram_cs_d;
         sram_wen_q  <= sram_wen_d;
         sram_addr_q <= sram_addr_d;
         sram_din_q  <= sram_din_d;
         rd_pipe_q   <= rd_pipe_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // FIFO storage needs no reset: only entries covered by count are read.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= req_if.req_addr;
         fifo_data_q[wr_ptr_q] <= req_if.req_wdata;
         fifo_wen_q[wr_ptr_q]  <= req_if.req_wen;
      end
   end

   assign req_if.req_ready = ready;
   assign req_if.rsp_valid = rd_pipe_q[RD_LAT];
   assign req_if.rsp_rdata = rsp_rdata_q;
   assign sram_cs          = sram_cs_q;
   assign sram_wen         = sram_wen_q;
   assign sram_addr        = sram_addr_q;
   assign sram_din         = sram_din_q;
   assign busy             = (count_q != '0) || sram_cs_q || (|rd_pipe_q);

`ifdef SRAM_REQ_SCHED_STAT_EN
   logic [31:0] wr_cnt_q, wr_cnt_d;
   logic [31:0] rd_cnt_q, rd_cnt_d;

   // Saturating statistics: writes counted on their issue edge, reads on the
   // edge that raises the response strobe.
   always_comb begin
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      if (sram_cs_d && sram_wen_d && (wr_cnt_q != '1)) begin
         wr_cnt_d = wr_cnt_q + 32'd1;
      end
      if (rd_pipe_d[RD_LAT] && (rd_cnt_q != '1)) begin
         rd_cnt_d = rd_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
      end
   end

   assign wr_cnt = wr_cnt_q;
   assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_sram_req_sched.sv
// -----------------------------------------------------------------------------
// tb_sram_req_sched
//   Self-checking bench for sram_req_sched. A behavioural SRAM with fixed read
//   latency sits on the pin side. The reference model works per request: each
//   accepted request is assigned the edge it must issue on (one after accept,
//   never earlier than one after the previous issue), reads get a response
//   due RD_LAT+1 edges after issue with data from a reference memory updated
//   in acceptance order, and busy is expected until the last such deadline.
// -----------------------------------------------------------------------------
module tb_sram_req_sched;
   localparam int ADDR_W     = 15;
   localparam int DATA_W     = 256;
   localparam int FIFO_DEPTH = 4;
   localparam int RD_LAT     = 2;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              wen;
      int                issue;
   } cmd_t;

   typedef struct {
      logic [DATA_W-1:0] data;
      int                due;
   } rsp_t;

   logic              clk = 1'b0;
   logic              rstn = 1'b0;
   logic              sram_cs;
   logic              sram_wen;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_din;
   logic [DATA_W-1:0] sram_dout;
   logic              busy;
`ifdef SRAM_REQ_SCHED_STAT_EN
   logic [31:0]       wr_cnt;
   logic [31:0]       rd_cnt;
   int                exp_wr = 0;
   int                exp_rd = 0;
`endif

   sram_req_sched_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) req_if ();

   sram_req_sched #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req_if    (req_if.slave),
      .sram_cs   (sram_cs),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .sram_wen  (sram_wen),
      .sram_dout (sram_dout),
      .busy      (busy)
`ifdef SRAM_REQ_SCHED_STAT_EN
      ,
      .wr_cnt    (wr_cnt),
      .rd_cnt    (rd_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Edge counter: after the n-th rising edge cyc reads n.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAM: samples commands on the rising edge, read data valid
   // RD_LAT edges later; junk is driven whenever no read is returning.
   logic [DATA_W-1:0] sram_arr [int];
   logic [DATA_W-1:0] dpipe [RD_LAT];
   assign sram_dout = dpipe[RD_LAT-1];

   always @(posedge clk) begin
      if (sram_cs && sram_wen) sram_arr[int'(sram_addr)] = sram_din;
      for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
      if (sram_cs && !sram_wen)
         dpipe[0] <= sram_arr.exists(int'(sram_addr)) ? sram_arr[int'(sram_addr)] : '0;
      else
         dpipe[0] <= {8{$urandom()}};
   end

   // Reference model state
   cmd_t              cmd_q [$];
   rsp_t              rsp_q [$];
   int                occ_q [$];
   logic [DATA_W-1:0] ref_mem [int];
   int                last_issue = -100;
   int                max_end = -1;
   bit                ready_chk = 0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                              input logic [DATA_W-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One cycle of request drive; records the acceptance in the model.
   task automatic applyStimulus(input logic v, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic w,
                                output logic acc);
      int   k;
      cmd_t c;
      rsp_t r;
      @(negedge clk);
      req_if.req_valid = v;
      req_if.req_addr  = a;
      req_if.req_wdata = d;
      req_if.req_wen   = w;
      #1;
      k = cyc + 1;
      while (occ_q.size() != 0 && occ_q[0] < k) occ_q.delete(0);
      if (ready_chk)
         checkOutput("req_ready", DATA_W'(req_if.req_ready), DATA_W'(occ_q.size() != FIFO_DEPTH));
      acc = v && req_if.req_ready;
      if (acc) begin
         c.issue    = (k + 1 > last_issue + 1) ? k + 1 : last_issue + 1;
         last_issue = c.issue;
         c.addr     = a;
         c.data     = d;
         c.wen      = w;
         cmd_q.push_back(c);
         occ_q.push_back(c.issue);
         if (w) begin
            ref_mem[int'(a)] = d;
            if (c.issue > max_end) max_end = c.issue;
         end else begin
            r.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
            r.due  = c.issue + 1 + RD_LAT;
            rsp_q.push_back(r);
            if (r.due > max_end) max_end = r.due;
         end
      end
   endtask

   task automatic sendReq(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic w);
      logic acc;
      int   tries;
      tries = 0;
      acc   = 1'b0;
      while (!acc && tries < 20) begin
         applyStimulus(1'b1, a, d, w, acc);
         tries++;
      end
      if (!acc) checkOutput("accept_timeout", '0, DATA_W'(1));
   endtask

   task automatic idle(input int n);
      logic acc;
      for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, acc);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cs"},    DATA_W'(sram_cs), '0);
      checkOutput({tag, "_wen"},   DATA_W'(sram_wen), '0);
      checkOutput({tag, "_addr"},  DATA_W'(sram_addr), '0);
      checkOutput({tag, "_din"},   sram_din, '0);
      checkOutput({tag, "_rsp_v"}, DATA_W'(req_if.rsp_valid), '0);
      checkOutput({tag, "_rdata"}, req_if.rsp_rdata, '0);
      checkOutput({tag, "_busy"},  DATA_W'(busy), '0);
      checkOutput({tag, "_ready"}, DATA_W'(req_if.req_ready), '0);
   endtask

   // Pin-side monitor: every cycle compares command pins, responses and busy
   // against the model's deadlines.
   cmd_t mc;
   rsp_t mr;
   logic exp_cs;
   logic exp_rv;
   always @(negedge clk) begin
      exp_cs = (cmd_q.size() != 0) && (cmd_q[0].issue == cyc);
      checkOutput("sram_cs", DATA_W'(sram_cs), DATA_W'(exp_cs));
      if (exp_cs) begin
         mc = cmd_q.pop_front();
         checkOutput("sram_addr", DATA_W'(sram_addr), DATA_W'(mc.addr));
         checkOutput("sram_wen", DATA_W'(sram_wen), DATA_W'(mc.wen));
         if (mc.wen) checkOutput("sram_din", sram_din, mc.data);
`ifdef SRAM_REQ_SCHED_STAT_EN
         if (mc.wen) exp_wr++;
`endif
      end else begin
         checkOutput("idle_wen", DATA_W'(sram_wen), '0);
         checkOutput("idle_din", sram_din, '0);
      end
      exp_rv = (rsp_q.size() != 0) && (rsp_q[0].due == cyc);
      checkOutput("rsp_valid", DATA_W'(req_if.rsp_valid), DATA_W'(exp_rv));
      if (exp_rv) begin
         mr = rsp_q.pop_front();
         checkOutput("rsp_rdata", req_if.rsp_rdata, mr.data);
`ifdef SRAM_REQ_SCHED_STAT_EN
         exp_rd++;
`endif
      end
      checkOutput("busy", DATA_W'(busy), DATA_W'(cyc <= max_end));
`ifdef SRAM_REQ_SCHED_STAT_EN
      checkOutput("wr_cnt", DATA_W'(wr_cnt), DATA_W'(exp_wr));
      checkOutput("rd_cnt", DATA_W'(rd_cnt), DATA_W'(exp_rd));
`endif
   end

   initial begin
      logic acc;
      req_if.req_valid = 1'b0;
      req_if.req_addr  = '0;
      req_if.req_wdata = '0;
      req_if.req_wen   = 1'b0;

      // Power-on reset
      repeat (3) @(negedge clk);
      #1;
      checkResetValues("por");
      @(negedge clk);
      rstn = 1'b1;
      idle(4);
      ready_chk = 1;
      $display("[TB] reset released, starting directed traffic");

      // Single write, then read back the same address
      sendReq(15'h0010, {32{8'hA5}}, 1'b1);
      idle(4);
      sendReq(15'h0010, '0, 1'b0);
      idle(6);

      // Consecutive requests to addresses 0..7, then back-to-back reads
      for (int i = 0; i < 8; i++) sendReq(ADDR_W'(i), {8{$urandom()}}, 1'b1);
      idle(3);
      for (int i = 0; i < 8; i++) sendReq(ADDR_W'(i), '0, 1'b0);
      idle(8);

      // Randomised mixed traffic over a small address window
      repeat (300) begin
         applyStimulus($urandom_range(0, 3) != 0, ADDR_W'($urandom_range(0, 15)),
                       {8{$urandom()}}, 1'($urandom_range(0, 1)), acc);
      end
      idle(8);

      // Reset in the middle of a read stream
      for (int i = 0; i < 6; i++) applyStimulus(1'b1, ADDR_W'(i), '0, 1'b0, acc);
      #2;
      rstn = 1'b0;
      cmd_q.delete();
      rsp_q.delete();
      occ_q.delete();
      max_end    = -1;
      last_issue = -100;
      ready_chk  = 0;
`ifdef SRAM_REQ_SCHED_STAT_EN
      exp_wr = 0;
      exp_rd = 0;
`endif
      #1;
      checkResetValues("midrst");
      req_if.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      ref_mem = sram_arr;
      idle(4);
      ready_chk = 1;
      idle(6);
      sendReq(ADDR_W'(3), '0, 1'b0);
      idle(8);

      checkOutput("cmd_drained", DATA_W'(cmd_q.size()), '0);
      checkOutput("rsp_drained", DATA_W'(rsp_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global time limit so the bench always reaches its summary.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
